// File: rtl/mul_div_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mul_div_pkg;

  localparam int ITER_COUNT = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Operand registers, 64-bit accumulator, shift-add / restoring-divide step and
// sign fix-up; sequenced by the strobes from the controller FSM.
module mul_div_datapath
  import mul_div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            prep_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            dbz_o
);

  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              res_neg_q, res_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              dbz_q, dbz_d;

  logic              is_div, is_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b, addend, quo, rem;
  logic [XLEN:0]     mul_sum, trial, diff;
  logic [2*XLEN-1:0] prod_neg;

  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    is_div  = op_is_div(op_q);
    is_sgn  = op_is_signed(op_q);
    a_neg   = is_sgn & a_q[XLEN-1];
    b_neg   = is_sgn & b_q[XLEN-1];
    // Negating -2^(XLEN-1) wraps to itself, which is the correct unsigned magnitude.
    mag_a   = a_neg ? (-a_q) : a_q;
    mag_b   = b_neg ? (-b_q) : b_q;

    addend  = acc_q[0] ? opnd_q : '0;
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
    trial   = acc_q[2*XLEN-1:XLEN-1];
    diff    = trial - {1'b0, opnd_q};

    prod_neg = -acc_q;
    quo      = res_neg_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem      = rem_neg_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    if (load_i) begin
      op_d = op_i;
      a_d  = a_i;
      b_d  = b_i;
    end

    if (prep_i) begin
      res_neg_d = a_neg ^ b_neg;
      rem_neg_d = a_neg;
      opnd_d    = is_div ? mag_b : mag_a;
      acc_d     = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
    end

    // Multiply: LO holds the remaining multiplier bits, HI collects the product.
    // Divide: LO shifts in quotient bits, HI holds the partial remainder.
    if (step_i) begin
      if (!is_div) begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
        acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end

    if (fix_i) begin
      if (is_div && (b_q == '0)) begin
        hi_d  = a_q;
        lo_d  = '1;
        dbz_d = 1'b1;
      end else if (is_div) begin
        hi_d  = rem;
        lo_d  = quo;
        dbz_d = 1'b0;
      end else begin
        {hi_d, lo_d} = res_neg_q ? prod_neg : acc_q;
        dbz_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hi_o  = hi_q;
  assign lo_o  = lo_q;
  assign dbz_o = dbz_q;

endmodule

// File: rtl/mul_div_sequencer.sv
// Controller for the iterative MULT/DIV unit: fixed 35-cycle latency FSM,
// iteration counter, registered BUSY/DONE handshake and datapath strobes.
module mul_div_sequencer
  import mul_div_pkg::*;
#(
  parameter int XLEN = ITER_COUNT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [1:0]      OP,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            DIV_BY_ZERO,
  output logic [2:0]      STATE_DBG
);

  localparam int CW = $clog2(XLEN);

  // Handshake: a request is accepted on the rising edge where START=1,
  // FLUSH=0 and the unit is in IDLE or DONE; requests at any other time are
  // dropped. BUSY is high from the edge after acceptance until the result
  // edge; DONE is a one-cycle pulse on which HI/LO/DIV_BY_ZERO are valid.
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;

  logic            accept, prep_en, step_en, fix_en;

  assign accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) && START && !FLUSH;
  assign prep_en = (state_q == S_PREP) && !FLUSH;
  assign step_en = (state_q == S_ITER) && !FLUSH;
  assign fix_en  = (state_q == S_FIX)  && !FLUSH;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q <= S_PREP;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_PREP: begin
          if (FLUSH) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_ITER;
            cnt_q   <= CW'(XLEN - 1);
          end
        end
        S_ITER: begin
          if (FLUSH) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          if (FLUSH) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mul_div_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (accept),
    .prep_i (prep_en),
    .step_i (step_en),
    .fix_i  (fix_en),
    .op_i   (OP),
    .a_i    (OPERAND_A),
    .b_i    (OPERAND_B),
    .hi_o   (HI),
    .lo_o   (LO),
    .dbz_o  (DIV_BY_ZERO)
  );

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign STATE_DBG = state_q;

endmodule
